// File: rtl/fpnew_pkg.sv
// fpnew_pkg (slice) -- shared FPU type definitions.
// Only the floating-point exception status record is needed by the cast
// result buffer; it matches the layout used throughout the FPU.
package fpnew_pkg;

    // IEEE 754 exception flags: invalid, div-by-zero, overflow, underflow, inexact
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_cast_result_buffer.sv
// fpnew_cast_result_buffer -- small in-order result buffer placed after the
// cast pipeline output stage. Holds up to Depth results with their status
// flags and sideband, decoupling the pipeline from downstream backpressure.
// in_ready_o depends only on registered occupancy, so there is no
// combinational path from out_ready_i back into the pipeline.
//
// Optional feature: define FPNEW_RESBUF_FALLTHROUGH_EN to let a result that
// arrives while the buffer is empty appear on the outputs in the same cycle
// (and bypass storage entirely if it is consumed immediately).
module fpnew_cast_result_buffer #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 2,
    parameter type         TagType = logic,
    parameter type         AuxType = logic
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [Width-1:0]   result_i,
    input  fpnew_pkg::status_t status_i,
    input  TagType             tag_i,
    input  AuxType             aux_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               flush_i,
    output logic [Width-1:0]   result_o,
    output fpnew_pkg::status_t status_o,
    output TagType             tag_o,
    output AuxType             aux_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    if (Depth < 1 || Depth > 16) begin : g_depth_check
        $error("fpnew_cast_result_buffer: Depth must lie in 1..16");
    end

    logic [Width-1:0]   result_q [Depth];
    fpnew_pkg::status_t status_q [Depth];
    TagType             tag_q    [Depth];
    AuxType             aux_q    [Depth];

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    logic empty;
    logic full;
    logic fall_through;
    logic push;
    logic pop;

    // Pointers wrap from the last entry back to zero (Depth need not be a power of two)
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign empty      = (count_q == '0);
    assign full       = (count_q == DepthCnt);
    assign in_ready_o = ~full;
    assign busy_o     = ~empty;

`ifdef FPNEW_RESBUF_FALLTHROUGH_EN
    // An arrival into an empty buffer is presented immediately; flush kills it
    assign fall_through = empty & in_valid_i & ~flush_i;
`else
    assign fall_through = 1'b0;
`endif

    assign out_valid_o = ~empty | fall_through;

    // A fall-through result taken in the same cycle never touches storage
    assign push = in_valid_i & in_ready_o & ~flush_i & ~(fall_through & out_ready_i);
    assign pop  = ~empty & out_ready_i & ~flush_i;

    assign result_o = fall_through ? result_i : result_q[rd_ptr_q];
    assign status_o = fall_through ? status_i : status_q[rd_ptr_q];
    assign tag_o    = fall_through ? tag_i    : tag_q[rd_ptr_q];
    assign aux_o    = fall_through ? aux_i    : aux_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush discards everything held
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; cleared on reset so idle outputs read as zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
                tag_q[i]    <= '0;
                aux_q[i]    <= '0;
            end
        end else if (push) begin
            result_q[wr_ptr_q] <= result_i;
            status_q[wr_ptr_q] <= status_i;
            tag_q[wr_ptr_q]    <= tag_i;
            aux_q[wr_ptr_q]    <= aux_i;
        end
    end

endmodule

// File: tb/tb_fpnew_cast_result_buffer.sv
// Directed testbench for fpnew_cast_result_buffer: a Depth=2 instance (a_*)
// for fill/drain/stream/flush/reset scenarios and a Depth=3 instance (b_*)
// for pointer wrap under irregular backpressure. Honours
// FPNEW_RESBUF_FALLTHROUGH_EN when deciding expected latency.
module tb_fpnew_cast_result_buffer;

    typedef logic [3:0] tag_t;
    typedef logic [1:0] aux_t;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0]        a_result, a_result_o;
    fpnew_pkg::status_t a_status, a_status_o;
    tag_t               a_tag, a_tag_o;
    aux_t               a_aux, a_aux_o;
    logic a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_busy;

    logic [63:0]        b_result, b_result_o;
    fpnew_pkg::status_t b_status, b_status_o;
    tag_t               b_tag, b_tag_o;
    aux_t               b_aux, b_aux_o;
    logic b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;

    fpnew_cast_result_buffer #(.Width(64), .Depth(2), .TagType(tag_t), .AuxType(aux_t)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni),
        .result_i(a_result), .status_i(a_status), .tag_i(a_tag), .aux_i(a_aux),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .flush_i(a_flush),
        .result_o(a_result_o), .status_o(a_status_o), .tag_o(a_tag_o), .aux_o(a_aux_o),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .busy_o(a_busy)
    );

    fpnew_cast_result_buffer #(.Width(64), .Depth(3), .TagType(tag_t), .AuxType(aux_t)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni),
        .result_i(b_result), .status_i(b_status), .tag_i(b_tag), .aux_i(b_aux),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .flush_i(b_flush),
        .result_o(b_result_o), .status_o(b_status_o), .tag_o(b_tag_o), .aux_o(b_aux_o),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .busy_o(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [63:0] v, input logic [4:0] st, input tag_t tg, input aux_t ax);
        a_in_valid = 1'b1;
        a_result   = v;
        a_status   = fpnew_pkg::status_t'(st);
        a_tag      = tg;
        a_aux      = ax;
    endtask

    task automatic test_reset();
        a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_result = '0; a_status = '0; a_tag = '0; a_aux = '0;
        b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_result = '0; b_status = '0; b_tag = '0; b_aux = '0;
        rst_ni = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
        tick(); #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_result_o !== 64'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", a_result_o); end
        checks++; if (a_status_o !== 5'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", a_status_o); end
        checks++; if (a_tag_o !== 4'h0 || a_aux_o !== 2'h0) begin failures++; $display("FAIL reset_side got=%h/%h exp=0/0", a_tag_o, a_aux_o); end
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b got=%b%b exp=01", b_out_valid, b_in_ready); end
    endtask

    task automatic test_fill();
        tick();
        a_out_ready = 1'b0;
        push_a(64'h11, 5'h01, 4'h1, 2'h1); #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready0 got=%b exp=1", a_in_ready); end
        tick();
        push_a(64'h22, 5'h02, 4'h2, 2'h2); #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready1 got=%b exp=1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b1 || a_result_o !== 64'h11) begin failures++; $display("FAIL fill_head1 got=%b/%h exp=1/11", a_out_valid, a_result_o); end
        tick();
        push_a(64'h33, 5'h03, 4'h3, 2'h3); #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b exp=0", a_in_ready); end
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL fill_busy got=%b exp=1", a_busy); end
        checks++; if (a_status_o !== 5'h01 || a_tag_o !== 4'h1) begin failures++; $display("FAIL fill_head_side got=%h/%h exp=01/1", a_status_o, a_tag_o); end
        tick();
        a_in_valid = 1'b0; #1;
        checks++; if (a_result_o !== 64'h11 || a_in_ready !== 1'b0) begin failures++; $display("FAIL fill_hold got=%h/%b exp=11/0", a_result_o, a_in_ready); end
    endtask

    task automatic test_drain();
        a_out_ready = 1'b1; #1;
        checks++; if (a_out_valid !== 1'b1 || a_result_o !== 64'h11 || a_aux_o !== 2'h1) begin failures++; $display("FAIL drain_first got=%b/%h/%h exp=1/11/1", a_out_valid, a_result_o, a_aux_o); end
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_result_o !== 64'h22) begin failures++; $display("FAIL drain_second got=%b/%h exp=1/22", a_out_valid, a_result_o); end
        checks++; if (a_status_o !== 5'h02 || a_tag_o !== 4'h2) begin failures++; $display("FAIL drain_second_side got=%h/%h exp=02/2", a_status_o, a_tag_o); end
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b%b%b exp=010", a_out_valid, a_in_ready, a_busy); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 10; k++) begin
            tick();
            a_out_ready = 1'b1;
            push_a(64'(k + 1), 5'h0, 4'(k), 2'h0); #1;
`ifdef FPNEW_RESBUF_FALLTHROUGH_EN
            checks++; if (a_out_valid !== 1'b1 || a_result_o !== 64'(k + 1)) begin failures++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", k, a_out_valid, a_result_o, k + 1); end
`else
            if (k == 0) begin
                checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_first_latency got=%b exp=0", a_out_valid); end
            end else begin
                checks++; if (a_out_valid !== 1'b1 || a_result_o !== 64'(k)) begin failures++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", k, a_out_valid, a_result_o, k); end
            end
`endif
        end
        tick();
        a_in_valid = 1'b0; #1;
`ifdef FPNEW_RESBUF_FALLTHROUGH_EN
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL stream_tail got=%b/%b exp=0/0", a_out_valid, a_busy); end
`else
        checks++; if (a_out_valid !== 1'b1 || a_result_o !== 64'd10) begin failures++; $display("FAIL stream_tail got=%b/%h exp=1/a", a_out_valid, a_result_o); end
`endif
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL stream_empty got=%b/%b exp=0/0", a_out_valid, a_busy); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_flush();
        tick();
        push_a(64'hA1, 5'h0, 4'h0, 2'h0);
        tick();
        push_a(64'hA2, 5'h0, 4'h0, 2'h0);
        tick();
        push_a(64'hA3, 5'h1F, 4'hF, 2'h3);
        a_flush = 1'b1; a_out_ready = 1'b1; #1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", a_in_ready); end
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL flush_cleared got=%b%b%b exp=010", a_out_valid, a_in_ready, a_busy); end
        tick();
        push_a(64'hB1, 5'h04, 4'h5, 2'h1);
        tick();
        a_in_valid = 1'b0; #1;
        checks++; if (a_out_valid !== 1'b1 || a_result_o !== 64'hB1) begin failures++; $display("FAIL flush_after_push got=%b/%h exp=1/b1", a_out_valid, a_result_o); end
        a_out_ready = 1'b1;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL flush_no_stale got=%b/%b exp=0/0", a_out_valid, a_busy); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] pat;
        int  sent;
        int  got;
        int  occ;
        int  cyc;
        bit  ft;
        bit  exp_valid;
        bit  push;
        pat  = 32'hFFFF_FD68;
        sent = 0; got = 0; occ = 0; cyc = 0;
        while (got < 7 && cyc < 60) begin
            tick();
            b_in_valid  = (sent < 7);
            b_result    = 64'h100 + 64'(sent);
            b_status    = fpnew_pkg::status_t'(5'(sent + 1));
            b_tag       = 4'(sent * 3);
            b_aux       = 2'(sent);
            b_out_ready = pat[cyc];
            #1;
            ft = 1'b0;
`ifdef FPNEW_RESBUF_FALLTHROUGH_EN
            ft = (occ == 0) && b_in_valid;
`endif
            exp_valid = (occ != 0) || ft;
            checks++; if (b_in_ready !== (occ < 3)) begin failures++; $display("FAIL wrap_ready_c%0d got=%b exp=%b", cyc, b_in_ready, occ < 3); end
            checks++; if (b_out_valid !== exp_valid) begin failures++; $display("FAIL wrap_valid_c%0d got=%b exp=%b", cyc, b_out_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (b_result_o !== 64'h100 + 64'(got) || b_status_o !== 5'(got + 1) || b_tag_o !== 4'(got * 3)) begin
                    failures++;
                    $display("FAIL wrap_data_c%0d got=%h/%h/%h exp=%h/%h/%h", cyc, b_result_o, b_status_o, b_tag_o,
                             64'h100 + 64'(got), 5'(got + 1), 4'(got * 3));
                end
            end
            push = b_in_valid && (occ < 3);
            if (ft && b_out_ready) begin
                got++; sent++;
            end else begin
                if (exp_valid && b_out_ready) begin got++; occ--; end
                if (push) begin sent++; occ++; end
            end
            cyc++;
        end
        checks++; if (got != 7) begin failures++; $display("FAIL wrap_timeout got=%0d results exp=7", got); end
        b_in_valid = 1'b0;
        tick();
        checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b/%b exp=0/0", b_out_valid, b_busy); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        tick();
        push_a(64'hC1, 5'h08, 4'h7, 2'h2);
        tick();
        push_a(64'hC2, 5'h10, 4'h8, 2'h3);
        tick();
        a_in_valid = 1'b0; #1;
        checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin failures++; $display("FAIL midrst_pre got=%b%b exp=10", a_out_valid, a_in_ready); end
        rst_ni = 1'b0;
        push_a(64'h99, 5'h1F, 4'hF, 2'h3);
        a_out_ready = 1'b1;
        tick();
        rst_ni = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%b%b%b exp=010", a_out_valid, a_in_ready, a_busy); end
        checks++; if (a_result_o !== 64'h0 || a_status_o !== 5'h0) begin failures++; $display("FAIL midrst_payload got=%h/%h exp=0/0", a_result_o, a_status_o); end
        checks++; if (a_tag_o !== 4'h0 || a_aux_o !== 2'h0) begin failures++; $display("FAIL midrst_side got=%h/%h exp=0/0", a_tag_o, a_aux_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_wrap();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpnew_cast_result_buffer.md
FPNEW_CAST_RESULT_BUFFER -- requirements
Module: fpnew_cast_result_buffer

Interface
REQ-001 Parameter Width, default 64, result payload width in bits.
REQ-002 Parameter Depth, default 2, number of buffer entries; legal range 1..16.
REQ-003 Parameter TagType, default logic, operation tag type carried with each result.
REQ-004 Parameter AuxType, default logic, auxiliary sideband type carried with each result.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset, synchronous and active-low.
REQ-007 result_i  input  Width  result from the cast pipeline output stage.
REQ-008 status_i  input  fpnew_pkg::status_t  exception flags for result_i.
REQ-009 tag_i / aux_i  input  TagType / AuxType  sideband for result_i.
REQ-010 in_valid_i  input  1  upstream pipeline presents a result.
REQ-011 in_ready_o  output  1  buffer accepts a result this cycle; drives the pipeline's out_ready_i.
REQ-012 flush_i  input  1  synchronous discard of all buffered results.
REQ-013 result_o / status_o / tag_o / aux_o  output  as inputs  head-entry payload.
REQ-014 out_valid_o  output  1  head entry valid.
REQ-015 out_ready_i  input  1  downstream consumes head entry.
REQ-016 busy_o  output  1  at least one result held.

Function
REQ-017 Storage: circular buffer of Depth entries {result, status, tag, aux}; write pointer, read pointer, occupancy count of width $clog2(Depth+1).
REQ-018 in_ready_o SHALL equal (count < Depth); no combinational path from out_ready_i to in_ready_o.
REQ-019 Push on in_valid_i & in_ready_o: entry written at write pointer, pointer advances, wraps Depth-1 -> 0.
REQ-020 Pop on out_valid_o & out_ready_i: read pointer advances with identical wrap rule.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-022 Full (count == Depth): in_ready_o low, in_valid_i ignored, held data unchanged.
REQ-023 Empty (count == 0): out_valid_o low (fall-through exception REQ-031); payload outputs show entry at read pointer.
REQ-024 Results leave strictly in arrival order; no reordering, drop or duplication.
REQ-025 Latency without fall-through: result accepted in cycle N is first visible on out_valid_o in cycle N+1.
REQ-026 Flush: count and both pointers cleared next cycle; flush overrides a same-cycle push and pop; out_valid_o low the cycle after flush.
REQ-027 busy_o SHALL equal (count != 0).

Reset
REQ-028 On rst_ni low at a clock edge: count and pointers 0, all storage '0.
REQ-029 After reset: out_valid_o 0, in_ready_o 1, busy_o 0, result_o/status_o/tag_o/aux_o all '0.
REQ-030 Reset asserted mid-operation discards all held results identically to REQ-028 regardless of handshake state.

Configuration
REQ-031 Macro FPNEW_RESBUF_FALLTHROUGH_EN defined: when count == 0 and in_valid_i high, out_valid_o high same cycle with payload = inputs; if out_ready_i also high, result passes without storage and count stays 0; flush_i high suppresses fall-through.
REQ-032 Macro undefined: behaviour per REQ-025, outputs driven only from storage.

Structure
REQ-033 fpnew_pkg::status_t reused from fpnew_pkg; no new package types; Depth legality checked by elaboration assertion.
REQ-034 No sub-module; single flat module.

Verification
REQ-035 Depth=2, reset, push results 0x11, 0x22 back-to-back with out_ready_i=0 -> in_ready_o low from cycle 2, count 2, busy_o 1.
REQ-036 Continue REQ-035, raise out_ready_i -> 0x11 then 0x22 on consecutive cycles, then out_valid_o 0, in_ready_o 1.
REQ-037 Continuous push/pop 10 results 1..10 with out_ready_i=1 -> outputs 1..10 in order, 1-cycle latency (macro off), 0-cycle (macro on).
REQ-038 Full buffer, flush_i with in_valid_i=1 same cycle -> next cycle count 0, out_valid_o 0, pushed result absent.
REQ-039 Depth=3, 7 pushes interleaved with pops under random out_ready_i -> pointer wrap, order and status/tag match scoreboard.
REQ-040 Reset asserted while full and out_valid_o=1 -> next cycle out_valid_o 0, in_ready_o 1, payload outputs '0.
